fn_sw_core: RTL and testbench
=============================

# fn_sw_core

Function-switch datapath element: a selector bit chooses between two bitwise logic functions of operands `a` and `b`, AND when `sel=0` and XOR when `sel=1`. Two result paths are provided. One is a combinational result. The other is a registered result with a valid flag and status flags. It sits as a small ALU leaf in control/datapath logic, and its default 1-bit configuration is the classic 3-input function switch.

## Interface
Parameters:
- `WIDTH`, default 1: operand/result width in bits, legal range 1..64.
- `CNT_W`, default 16: width of the optional statistics counters.

Ports (clock and reset first):
- `clk`, input, 1: the single clock; all state updates on its rising edge.
- `rst`, input, 1: reset, synchronous, active-high.
- `in_valid`, input, 1: operands and `sel` are valid this cycle.
- `a`, input, WIDTH: operand A.
- `b`, input, WIDTH: operand B.
- `sel`, input, 1: function select; 0 selects `a & b`, 1 selects `a ^ b`.
- `y_comb`, output, WIDTH: combinational result of the current inputs; independent of `clk`, `rst` and `in_valid`.
- `y`, output, WIDTH: registered result.
- `out_valid`, output, 1: `y` holds a result captured on the previous cycle.
- `zero`, output, 1: registered; asserted when the captured result is all zeros.
- `parity`, output, 1: registered XOR-reduction of the captured result.
- `and_cnt`, output, CNT_W: present only with `FN_SW_STATS_EN`; counts accepted AND operations.
- `xor_cnt`, output, CNT_W: present only with `FN_SW_STATS_EN`; counts accepted XOR operations.

## Operation
- `y_comb` = `sel ? (a ^ b) : (a & b)` at all times; there is no state.
- On a rising edge with `rst=1`, the following values are loaded:
  - `y`, `parity`, `out_valid` = 0.
  - `zero` = 1.
  - Both counters, when present, = 0.
  - `rst` takes priority over `in_valid`.
- On a rising edge with `rst=0` and `in_valid=1`:
  - `y` is loaded with `y_comb`.
  - `zero` = (`y_comb`==0).
  - `parity` = ^`y_comb`.
  - `out_valid` = 1.
- On a rising edge with `rst=0` and `in_valid=0`:
  - `out_valid` = 0.
  - `y`, `zero` and `parity` hold their last values.
- Counters, when present: each accepted operation increments `and_cnt` if `sel=0`, or `xor_cnt` if `sel=1`. Each counter saturates at all-ones and does not wrap.
- `sel`, `a` or `b` being X or Z while `in_valid=0` must not affect registered state.
- No back-pressure: every `in_valid` cycle is accepted.

## Timing
- `y_comb` has zero-cycle latency and is purely combinational.
- `y`, `zero`, `parity` and `out_valid` have one-cycle latency: inputs sampled at edge N appear after edge N.
- Back-to-back `in_valid` produces a new result every cycle and keeps `out_valid` high continuously.
- Reset asserted mid-stream clears outputs at that edge; a result sampled on the same edge is discarded.
- Counters update on the same edge as `y`.

## Configuration
- Macro `FN_SW_STATS_EN`.
- Defined: the `and_cnt` and `xor_cnt` ports and their saturating counters are compiled in.
- Undefined: the ports and counters are absent. All other behaviour is identical and there is no extra logic.

## Test plan
- **Exhaustive 1-bit sweep:** `WIDTH=1`, with `{a,b,sel}` stepped through 000..111, one combination per 10 time units. Required `y_comb` sequence: 0,0,0,1,0,1,1,0. Registered `y` must match one cycle later while `in_valid=1`.
- **Reset:** assert `rst` for one edge with `in_valid=1`, `a=b=1`, `sel=0`. After the edge, required `y=0`, `zero=1`, `parity=0`, `out_valid=0`, counters 0.
- **Wide operands:** `WIDTH=8`, `a=8'hF0`, `b=8'h3C`.
  - `sel=0`: `y=8'h30`, `parity=0`, `zero=0`.
  - `sel=1`: `y=8'hCC`, `parity=0`.
  - `a=b=8'hAA` with `sel=1`: `y=0`, `zero=1`.
- **Valid gating:** issue one `in_valid` pulse, then deassert it for 3 cycles while `a`/`b` change. Required: `out_valid` high for exactly 1 cycle, and `y` holds the captured value.
- **Counters** (with `FN_SW_STATS_EN`, `CNT_W=2`):
  - 5 accepted AND ops and 2 XOR ops give `and_cnt=3` (saturated) and `xor_cnt=2`.
  - Ops presented with `in_valid=0` do not count.
- **Back-to-back:** alternate `sel` every cycle with `in_valid` held high for 8 cycles. Required: `out_valid` stays high, and each `y` equals the function selected on the previous cycle.

Source files
------------

// File: rtl/fn_sw_core.sv
// Function switch: y_comb = sel ? a^b : a&b now; y/zero/parity/out_valid one cycle later, no backpressure.
// FN_SW_STATS_EN adds saturating and_cnt/xor_cnt counters of accepted operations.
module fn_sw_core #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] y_comb,
  output logic [WIDTH-1:0] y,
  output logic             out_valid,
  output logic             zero,
  output logic             parity
`ifdef FN_SW_STATS_EN
  ,
  output logic [CNT_W-1:0] and_cnt,
  output logic [CNT_W-1:0] xor_cnt
`endif
);

  logic [WIDTH-1:0] y_q, y_d;
  logic             out_valid_q, out_valid_d;
  logic             zero_q, zero_d;
  logic             parity_q, parity_d;

  assign y_comb = sel ? (a ^ b) : (a & b);

  // Result flags hold between operations; only out_valid drops when idle.
  always_comb begin
    y_d         = y_q;
    zero_d      = zero_q;
    parity_d    = parity_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      y_d         = y_comb;
      zero_d      = (y_comb == '0);
      parity_d    = ^y_comb;
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q         <= '0;
      zero_q      <= 1'b1;
      parity_q    <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      y_q         <= y_d;
      zero_q      <= zero_d;
      parity_q    <= parity_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign y         = y_q;
  assign zero      = zero_q;
  assign parity    = parity_q;
  assign out_valid = out_valid_q;

`ifdef FN_SW_STATS_EN
  logic [CNT_W-1:0] and_cnt_q, and_cnt_d;
  logic [CNT_W-1:0] xor_cnt_q, xor_cnt_d;

  // sel is only looked at under in_valid so idle garbage never counts.
  always_comb begin
    and_cnt_d = and_cnt_q;
    xor_cnt_d = xor_cnt_q;
    if (in_valid) begin
      if (sel) begin
        if (xor_cnt_q != '1) xor_cnt_d = xor_cnt_q + CNT_W'(1);
      end else begin
        if (and_cnt_q != '1) and_cnt_d = and_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      and_cnt_q <= '0;
      xor_cnt_q <= '0;
    end else begin
      and_cnt_q <= and_cnt_d;
      xor_cnt_q <= xor_cnt_d;
    end
  end

  assign and_cnt = and_cnt_q;
  assign xor_cnt = xor_cnt_q;
`endif

endmodule

// File: tb/tb_fn_sw_core.sv
// Bench for fn_sw_core: a 1-bit instance for the truth-table sweep, an 8-bit instance for the rest.
`timescale 1ns/1ps
module tb_fn_sw_core;

  localparam int CW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, in_valid, sel;
  logic [0:0] a1, b1, y1c, y1;
  logic       out_valid1, zero1, parity1;
  logic [7:0] a8, b8, y8c, y8;
  logic       out_valid8, zero8, parity8;
`ifdef FN_SW_STATS_EN
  logic [15:0]   and_cnt1, xor_cnt1;
  logic [CW-1:0] and_cnt8, xor_cnt8;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [7:0] y;
    logic       zero;
    logic       parity;
  } exp_t;

  exp_t sb[$];
  logic sb1[$];

  fn_sw_core #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a1), .b(b1), .sel(sel),
    .y_comb(y1c), .y(y1), .out_valid(out_valid1), .zero(zero1), .parity(parity1)
`ifdef FN_SW_STATS_EN
    , .and_cnt(and_cnt1), .xor_cnt(xor_cnt1)
`endif
  );

  fn_sw_core #(.WIDTH(8), .CNT_W(CW)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a8), .b(b8), .sel(sel),
    .y_comb(y8c), .y(y8), .out_valid(out_valid8), .zero(zero8), .parity(parity8)
`ifdef FN_SW_STATS_EN
    , .and_cnt(and_cnt8), .xor_cnt(xor_cnt8)
`endif
  );

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b1; sel = 1'b0;
    a8 = 8'hFF; b8 = 8'hFF; a1 = 1'b1; b1 = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (y8 !== 8'hFF || out_valid8 !== 1'b1) begin
      n_bad++;
      $display("FAIL pre_reset_load: y=%h out_valid=%b, required y=ff out_valid=1", y8, out_valid8);
    end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({y8, zero8, parity8, out_valid8} !== {8'h00, 1'b1, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_w8: y=%h zero=%b parity=%b out_valid=%b, required 00 1 0 0",
               y8, zero8, parity8, out_valid8);
    end
    n_cmp++;
    if ({y1, zero1, parity1, out_valid1} !== {1'b0, 1'b1, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_w1: y=%b zero=%b parity=%b out_valid=%b, required 0 1 0 0",
               y1, zero1, parity1, out_valid1);
    end
`ifdef FN_SW_STATS_EN
    n_cmp++;
    if (and_cnt8 !== '0 || xor_cnt8 !== '0 || and_cnt1 !== '0 || xor_cnt1 !== '0) begin
      n_bad++;
      $display("FAIL reset_counters: and8=%0d xor8=%0d and1=%0d xor1=%0d, required all 0",
               and_cnt8, xor_cnt8, and_cnt1, xor_cnt1);
    end
`endif
    rst = 1'b0; in_valid = 1'b0;
    sb.delete(); sb1.delete();
  endtask

  task automatic test_sweep_1bit();
    logic [7:0] tab;
    logic       e;
    tab = 8'h68;  // bit i = required result for {a,b,sel} = i
    a8 = 8'h00; b8 = 8'h00;
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = i[2:0];
      a1 = v[2]; b1 = v[1]; sel = v[0]; in_valid = 1'b1;
      #1;
      n_cmp++;
      if (y1c !== tab[i]) begin
        n_bad++;
        $display("FAIL sweep_comb[%0d]: y_comb=%b, required %b", i, y1c, tab[i]);
      end
      sb1.push_back(tab[i]);
      @(negedge clk);
      e = sb1.pop_front();
      n_cmp++;
      if (y1 !== e || out_valid1 !== 1'b1) begin
        n_bad++;
        $display("FAIL sweep_reg[%0d]: y=%b out_valid=%b, required y=%b out_valid=1", i, y1, out_valid1, e);
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (out_valid1 !== 1'b0 || y1 !== 1'b0) begin
      n_bad++;
      $display("FAIL sweep_idle: y=%b out_valid=%b, required y=0 out_valid=0", y1, out_valid1);
    end
  endtask

  task automatic test_wide();
    logic [7:0] ta[3];
    logic [7:0] tb_v[3];
    logic       ts[3];
    exp_t       te[3];
    exp_t       e;
    ta = '{8'hF0, 8'hF0, 8'hAA};
    tb_v = '{8'h3C, 8'h3C, 8'hAA};
    ts = '{1'b0, 1'b1, 1'b1};
    te[0] = {8'h30, 1'b0, 1'b0};
    te[1] = {8'hCC, 1'b0, 1'b0};
    te[2] = {8'h00, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      a8 = ta[i]; b8 = tb_v[i]; sel = ts[i]; in_valid = 1'b1;
      #1;
      n_cmp++;
      if (y8c !== te[i].y) begin
        n_bad++;
        $display("FAIL wide_comb[%0d]: y_comb=%h, required %h", i, y8c, te[i].y);
      end
      sb.push_back(te[i]);
      @(negedge clk);
      e = sb.pop_front();
      n_cmp++;
      if ({y8, zero8, parity8, out_valid8} !== {e.y, e.zero, e.parity, 1'b1}) begin
        n_bad++;
        $display("FAIL wide_reg[%0d]: y=%h zero=%b parity=%b out_valid=%b, required %h %b %b 1",
                 i, y8, zero8, parity8, out_valid8, e.y, e.zero, e.parity);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_valid_gating();
    exp_t e;
    int   ov_hi;
    ov_hi = 0;
    a8 = 8'h5A; b8 = 8'h0F; sel = 1'b1; in_valid = 1'b1;
    sb.push_back({8'h55, 1'b0, 1'b0});
    @(negedge clk);
    ov_hi += int'(out_valid8);
    e = sb.pop_front();
    n_cmp++;
    if ({y8, zero8, parity8, out_valid8} !== {e.y, e.zero, e.parity, 1'b1}) begin
      n_bad++;
      $display("FAIL gate_capture: y=%h zero=%b parity=%b out_valid=%b, required 55 0 0 1",
               y8, zero8, parity8, out_valid8);
    end
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b0;
      a8 = (k == 2) ? 8'hxx : 8'($urandom);
      b8 = 8'($urandom);
      sel = (k == 1) ? 1'bx : 1'b0;
      @(negedge clk);
      ov_hi += int'(out_valid8);
      n_cmp++;
      if ({y8, zero8, parity8, out_valid8} !== {8'h55, 1'b0, 1'b0, 1'b0}) begin
        n_bad++;
        $display("FAIL gate_hold[%0d]: y=%h zero=%b parity=%b out_valid=%b, required 55 0 0 0",
                 k, y8, zero8, parity8, out_valid8);
      end
    end
    n_cmp++;
    if (ov_hi != 1) begin
      n_bad++;
      $display("FAIL gate_pulse_len: out_valid high %0d cycles, required 1", ov_hi);
    end
    sel = 1'b0; a8 = 8'h00; b8 = 8'h00;
  endtask

`ifdef FN_SW_STATS_EN
  task automatic test_counters();
    logic   v_t[10];
    logic   s_t[10];
    int     n_and, n_xor, e_and, e_xor;
    v_t = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    s_t = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    n_and = 0; n_xor = 0;
    rst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_valid = v_t[i]; sel = s_t[i]; a8 = 8'($urandom); b8 = 8'($urandom);
      if (v_t[i] && s_t[i]) n_xor++;
      if (v_t[i] && !s_t[i]) n_and++;
      e_and = (n_and > 3) ? 3 : n_and;
      e_xor = (n_xor > 3) ? 3 : n_xor;
      @(negedge clk);
      n_cmp++;
      if (int'(and_cnt8) != e_and || int'(xor_cnt8) != e_xor) begin
        n_bad++;
        $display("FAIL counters[%0d]: and_cnt=%0d xor_cnt=%0d, required %0d %0d",
                 i, and_cnt8, xor_cnt8, e_and, e_xor);
      end
    end
    n_cmp++;
    if (and_cnt8 !== 2'd3 || xor_cnt8 !== 2'd2) begin
      n_bad++;
      $display("FAIL counters_final: and_cnt=%0d xor_cnt=%0d, required 3 2", and_cnt8, xor_cnt8);
    end
    in_valid = 1'b0; sel = 1'b0;
  endtask
`endif

  task automatic test_back_to_back();
    exp_t e, got;
    for (int i = 0; i < 8; i++) begin
      sel = i[0]; a8 = 8'($urandom); b8 = 8'($urandom); in_valid = 1'b1;
      e.y      = sel ? (a8 ^ b8) : (a8 & b8);
      e.zero   = (e.y == 8'h00);
      e.parity = ^e.y;
      sb.push_back(e);
      @(negedge clk);
      got = sb.pop_front();
      n_cmp++;
      if ({y8, zero8, parity8, out_valid8} !== {got.y, got.zero, got.parity, 1'b1}) begin
        n_bad++;
        $display("FAIL b2b[%0d]: y=%h zero=%b parity=%b out_valid=%b, required %h %b %b 1",
                 i, y8, zero8, parity8, out_valid8, got.y, got.zero, got.parity);
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (out_valid8 !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_end: out_valid=%b, required 0", out_valid8);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; sel = 1'b0;
    a1 = 1'b0; b1 = 1'b0; a8 = 8'h00; b8 = 8'h00;
    repeat (2) @(negedge clk);
    test_reset();
    test_sweep_1bit();
    test_wide();
    test_valid_gating();
`ifdef FN_SW_STATS_EN
    test_counters();
`endif
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

endmodule
